// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between the MEM stage and a word-addressed data memory.
// Optional macro LSU_ALIGN_CHECK_EN: report misalignment/illegal size instead of forcing alignment.
module lsu_mem_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_WORDS  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    typedef enum logic [2:0] {IDLE, RD, RDW, WR, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] NUM_WORDS_W = ADDR_WIDTH'(NUM_WORDS);

    state_t                  state, state_nx;
    logic                    we_q, uns_q, err_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   word_q, rdata_q;

    logic [1:0]              eff_size;
    logic [ADDR_WIDTH-1:0]   eff_addr;
    logic                    align_err, range_err, req_err;
    logic [4:0]              sh_b, sh_h;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic [DATA_WIDTH-1:0]   load_v, merged;

    // Request decode: alignment policy and range check on the incoming request.
    always_comb begin
        eff_size = req_size;
        eff_addr = req_addr;
`ifdef LSU_ALIGN_CHECK_EN
        align_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
        align_err = 1'b0;
        if (req_size == 2'b11) eff_size = 2'b10;
        if (eff_size == 2'b01)      eff_addr[0]   = 1'b0;
        else if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        range_err = {2'b00, req_addr[ADDR_WIDTH-1:2]} >= NUM_WORDS_W;
        req_err   = align_err || range_err;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        sh_b   = {addr_q[1:0], 3'b000};
        sh_h   = {addr_q[1], 4'b0000};
        byte_v = 8'(mem_rdata >> sh_b);
        half_v = 16'(mem_rdata >> sh_h);
        case (size_q)
            2'b00:   load_v = uns_q ? {{(DATA_WIDTH-8){1'b0}}, byte_v}
                                    : {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            2'b01:   load_v = uns_q ? {{(DATA_WIDTH-16){1'b0}}, half_v}
                                    : {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            default: load_v = mem_rdata;
        endcase
        case (size_q)
            2'b00:   merged = (mem_rdata & ~(DATA_WIDTH'(8'hFF) << sh_b)) |
                              (DATA_WIDTH'(word_q[7:0]) << sh_b);
            2'b01:   merged = (mem_rdata & ~(DATA_WIDTH'(16'hFFFF) << sh_h)) |
                              (DATA_WIDTH'(word_q[15:0]) << sh_h);
            default: merged = word_q;
        endcase
    end

    // Handshake: a request is taken on a rising edge with req_valid && req_ready;
    // req_ready is high only in IDLE, responses are single-cycle with no backpressure.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                            state_nx = RESP;
                    else if (!req_we || eff_size != 2'b10)  state_nx = RD;
                    else                                    state_nx = WR;
                end
            end
            RD: begin
                mem_ren  = rst_n;
                state_nx = RDW;
            end
            RDW:  state_nx = we_q ? WR : RESP;
            WR: begin
                mem_wen  = rst_n;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = rst_n;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                we_q   <= req_we;
                uns_q  <= req_unsigned;
                err_q  <= req_err;
                size_q <= eff_size;
                addr_q <= eff_addr;
                word_q <= req_wdata;
            end
            if (state == RDW && we_q) word_q <= merged;
            // Response data changes only when a new response is about to be presented.
            if (state_nx == RESP)
                rdata_q <= (state == RDW && !we_q) ? load_v : '0;
        end
    end

    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_raddr  = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    assign mem_waddr  = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    assign mem_wdata  = word_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a behavioural 1-cycle-read memory and a response scoreboard.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = '0;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    logic [31:0] mem [0:127];
    logic [32:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          both_hi = 0;

    lsu_mem_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_raddr[6:0]];
        if (mem_wen) mem[mem_waddr[6:0]] <= mem_wdata;
    end

    always @(negedge clk) if (mem_ren && mem_wen) both_hi++;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; exp_ren/exp_wen/exp_cyc are cycle numbers after accept (-1 = none).
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input int exp_cyc,
                       input int exp_ren, input int exp_wen, input logic [31:0] exp_wdata);
        int ren_cyc = -1, wen_cyc = -1, ren_n = 0, wen_n = 0, resp_cyc = -1;
        logic [31:0] raddr_s = '0, waddr_s = '0, wdata_s = '0;
        logic [32:0] obs = '0;
        @(negedge clk);
        check({tag, ":ready_idle"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 12 && resp_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_ren) begin
                ren_n++;
                if (ren_cyc < 0) begin ren_cyc = c; raddr_s = mem_raddr; end
            end
            if (mem_wen) begin
                wen_n++;
                if (wen_cyc < 0) begin wen_cyc = c; waddr_s = mem_waddr; wdata_s = mem_wdata; end
            end
            if (resp_valid) begin
                resp_cyc = c;
                obs = {resp_err, resp_rdata};
                check({tag, ":ready_in_resp"}, req_ready, 0);
            end
        end
        check({tag, ":resp_cycle"}, 33'(resp_cyc), 33'(exp_cyc));
        if (exp_q.size() > 0) begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if (resp_cyc >= 0) check({tag, ":err_rdata"}, obs, e);
        end
        check({tag, ":ren_cycle"}, 33'(ren_cyc), 33'(exp_ren));
        check({tag, ":wen_cycle"}, 33'(wen_cyc), 33'(exp_wen));
        check({tag, ":ren_count"}, 33'(ren_n), (exp_ren < 0) ? 33'd0 : 33'd1);
        check({tag, ":wen_count"}, 33'(wen_n), (exp_wen < 0) ? 33'd0 : 33'd1);
        if (exp_ren >= 0) check({tag, ":raddr"}, raddr_s, {2'b00, addr[31:2]});
        if (exp_wen >= 0) begin
            check({tag, ":waddr"}, waddr_s, {2'b00, addr[31:2]});
            check({tag, ":wdata"}, wdata_s, exp_wdata);
        end
        if (resp_cyc >= 0) begin
            @(posedge clk);
            #1 check({tag, ":ready_after"}, req_ready, 1);
        end
    endtask

    initial begin
        int strobes;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[4]   = 32'h8899AABB;
        mem[127] = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst:req_ready", req_ready, 1);
        check("rst:resp_valid", resp_valid, 0);
        check("rst:resp_rdata", resp_rdata, 0);
        check("rst:resp_err", resp_err, 0);
        check("rst:mem_ren", mem_ren, 0);
        check("rst:mem_wen", mem_wen, 0);

        txn("lb_s_13",  0, 32'h13, 2'b00, 0, 0, 0, 32'hFFFFFF88, 3, 1, -1, 0);
        txn("lbu_11",   0, 32'h11, 2'b00, 1, 0, 0, 32'h000000AA, 3, 1, -1, 0);
        txn("lhu_12",   0, 32'h12, 2'b01, 1, 0, 0, 32'h00008899, 3, 1, -1, 0);
        txn("lh_12",    0, 32'h12, 2'b01, 0, 0, 0, 32'hFFFF8899, 3, 1, -1, 0);
        txn("sh_12",    1, 32'h12, 2'b01, 0, 32'hCAFE1234, 0, 0, 4, 1, 3, 32'h1234AABB);
        txn("lw_10",    0, 32'h10, 2'b10, 0, 0, 0, 32'h1234AABB, 3, 1, -1, 0);
        txn("sw_20",    1, 32'h20, 2'b10, 0, 32'hDEADBEEF, 0, 0, 2, -1, 1, 32'hDEADBEEF);
        txn("lw_20",    0, 32'h20, 2'b10, 0, 0, 0, 32'hDEADBEEF, 3, 1, -1, 0);
        txn("sb_21",    1, 32'h21, 2'b00, 0, 32'h1111115A, 0, 0, 4, 1, 3, 32'hDEAD5AEF);
        txn("lw_20b",   0, 32'h20, 2'b10, 0, 0, 0, 32'hDEAD5AEF, 3, 1, -1, 0);
`ifdef LSU_ALIGN_CHECK_EN
        txn("lw_22",    0, 32'h22, 2'b10, 0, 0, 1, 0, 1, -1, -1, 0);
        txn("l11_10",   0, 32'h10, 2'b11, 0, 0, 1, 0, 1, -1, -1, 0);
        txn("sh_13",    1, 32'h13, 2'b01, 0, 32'h5555, 1, 0, 1, -1, -1, 0);
`else
        txn("lw_22",    0, 32'h22, 2'b10, 0, 0, 0, 32'hDEAD5AEF, 3, 1, -1, 0);
        txn("l11_10",   0, 32'h10, 2'b11, 0, 0, 0, 32'h1234AABB, 3, 1, -1, 0);
        txn("lhu_13",   0, 32'h13, 2'b01, 1, 0, 0, 32'h00001234, 3, 1, -1, 0);
`endif
        txn("lw_200",   0, 32'h200, 2'b10, 0, 0, 1, 0, 1, -1, -1, 0);
        txn("sw_200",   1, 32'h200, 2'b10, 0, 32'h1, 1, 0, 1, -1, -1, 0);
        txn("lw_1fc",   0, 32'h1FC, 2'b10, 0, 0, 0, 32'h0BADF00D, 3, 1, -1, 0);
        txn("sw_after_err", 1, 32'h24, 2'b10, 0, 32'h01020304, 0, 0, 2, -1, 1, 32'h01020304);

        // Reset asserted during the RDW cycle of a byte store drops the transaction.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b00; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        strobes = 0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstmid:wen_in_reset", mem_wen, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rstmid:ready", req_ready, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_wen || resp_valid) strobes++;
        end
        check("rstmid:no_wen_resp", 33'(strobes), 0);
        check("rstmid:mem_word", mem[4], 32'h1234AABB);
        txn("rstmid:lw_10", 0, 32'h10, 2'b10, 0, 0, 0, 32'h1234AABB, 3, 1, -1, 0);

        check("exp_q_empty", 33'(exp_q.size()), 0);
        check("ren_wen_overlap", 33'(both_hi), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
